uart_rx: RTL and testbench
==========================

# uart_rx

Receive half of the APB UART. Deserialises the line input using a 16x oversampling tick and the same 5-bit frame configuration as the transmit path. Delivers each received character with a one-cycle valid strobe plus parity and framing error flags to the register/FIFO layer. Sits beside the transmitter, driven by the shared baud generator.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-cycle pulse at 16x baud rate.
- `rx_enable`  in  1  receiver enable; when low, start detection is inhibited.
- `cfg_reg`  in  5  [1:0] data bits − 5; [2] stop bits (0: 1, 1: 2); [3] parity enable; [4] parity type (0: even, 1: odd).
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  received character, LSB-aligned, unused upper bits zero.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` and the error flags are valid.
- `parity_err`  out  1  parity mismatch for the current character; valid with `rx_valid`.
- `frame_err`  out  1  a stop bit was sampled low; valid with `rx_valid`.
- `rx_busy`  out  1  high from start-edge detection until return to IDLE.

## Operation
- `rx` passes through a 2-FF synchroniser (reset value 1). All logic uses the synchronised value `rx_s`.
- Tick counter: 4 bits, advances only on `sample_tick`. Bit counter: 4 bits.
- IDLE: `rx_enable`=1 and `rx_s`=0 → latch `cfg_reg`, clear the shift register, clear the tick counter, go to START, raise `rx_busy`.
- START: on the 8th tick (mid-bit), sample the line.
  - Sample 0 → DATA; tick counter and bit counter cleared.
  - Sample 1 → glitch: back to IDLE, no `rx_valid`.
- DATA: every 16 ticks, sample at mid-bit and shift LSB-first into `rx_data[bit_counter]`.
  - After `cfg[1:0]`+5 bits → PARITY if parity is enabled, else STOP.
- PARITY: sample at mid-bit.
  - Expected bit = XOR of the received data bits (even); inverted when `cfg[4]`=1 (odd).
  - Mismatch sets the internal parity flag.
- STOP: sample at mid-bit; any 0 sets the internal frame flag.
  - With 2 stop bits, both are sampled, 16 ticks apart.
  - After the final stop sample: `rx_valid`=1 for one cycle, flags copied to `parity_err`/`frame_err`, state → IDLE, `rx_busy`=0.
- Return to IDLE is at mid-stop-bit, so a back-to-back start edge is caught.
- Frame error with a low line: the receiver returns to IDLE. If `rx_s` is still 0 there, that is treated as a new start edge (break behaviour; the start bit is re-validated).
- `cfg_reg` changes mid-frame have no effect until the next start.
- `rx_enable` deasserted mid-frame: the current frame completes normally.
- `rx_data`, `parity_err` and `frame_err` hold their values until the next `rx_valid`.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0, state IDLE, synchroniser=1.
- Start-edge latency: 2 `clk` from an `rx` fall to `rx_s` fall; 1 more cycle to `rx_busy`=1.
- `rx_valid` is registered: it rises on the `clk` edge after the `sample_tick` that completes the final stop sample.
- Frame length (ideal): start + N data + P + S bits. `rx_valid` arrives ≈ (1 + N + P + S − 0.5) × 16 ticks after the start edge, plus 3 `clk`.
- `sample_tick` and a start edge arriving in the same cycle: the edge wins and the tick is not counted.
- Synchronous `rst` mid-frame: immediate return to IDLE, all outputs to their reset values, no `rx_valid`.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of ticks 7, 8 and 9.
  - The decision is taken at tick 9.
- `UART_RX_MAJORITY_EN` undefined:
  - Single sample at tick 8.
  - The decision is taken at tick 8.
- Bit-period spacing (16 ticks) is identical in both builds.

## Test plan
- 8N1 (`cfg`=5'b00011), send 0xA5 → one `rx_valid`, `rx_data`=0xA5, `parity_err`=0, `frame_err`=0.
- 5E2 (`cfg`=5'b01100), send 0x13 with a correct even parity bit (1) → `rx_data`=0x13; the same character sent with parity 0 → `parity_err`=1.
- 7O1 (`cfg`=5'b11010), send 0x7F with stop bit forced 0 → `frame_err`=1, `rx_data`=0x7F, `parity_err`=0.
- 4-tick low glitch on `rx` while idle → no `rx_valid`; `rx_busy` pulses, then returns to 0 by tick 8 (tick 9 with the macro).
- Back-to-back 8N1 frames 0x00 then 0xFF with no idle gap → two `rx_valid` pulses with the correct data.
- `rst` asserted during data bit 3 → `rx_busy`=0 next cycle, no `rx_valid`; the next frame, 0x3C, is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Received-character bus from uart_rx to the register/FIFO layer.
// Latency: n/a (wires only). Backpressure: none, the consumer must take each rx_valid strobe.
// Modports: master drives the character, slave consumes it.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;

   modport master (output rx_data, rx_valid, parity_err, frame_err);
   modport slave  (input  rx_data, rx_valid, parity_err, frame_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser with 5-8 data bits, optional parity, 1/2 stop bits.
// Latency: rx_valid one clk after the tick that completes the final mid-stop sample. Backpressure: none.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote over ticks 7/8/9 instead of a single tick-8 sample.
module uart_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       rx_enable,
   input  logic [4:0] cfg_reg,
   input  logic       rx,
   output logic       rx_busy,
   uart_rx_if.master  rx_bus
);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] START_DEC = 4'd8;
`else
   localparam logic [3:0] START_DEC = 4'd7;
`endif
   // Bits after the start bit are one full period (16 ticks) after the start decision.
   localparam logic [3:0] BIT_DEC = 4'd15;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state;
   logic       rx_m;
   logic       rx_s;
   logic [3:0] tick_cnt;
   logic [3:0] bit_cnt;
   logic [4:0] cfg_q;
   logic [7:0] shift_q;
   logic       par_flag;
   logic       frame_flag;
   logic       dec_tick;
   logic       bit_val;
   logic       last_data;
`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_comb begin
      dec_tick  = sample_tick && (tick_cnt == ((state == START) ? START_DEC : BIT_DEC));
`ifdef UART_RX_MAJORITY_EN
      bit_val   = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
      bit_val   = rx_s;
`endif
      last_data = (bit_cnt == ({2'b00, cfg_q[1:0]} + 4'd4));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         tick_cnt          <= 4'd0;
         bit_cnt           <= 4'd0;
         cfg_q             <= 5'd0;
         shift_q           <= 8'd0;
         par_flag          <= 1'b0;
         frame_flag        <= 1'b0;
         rx_busy           <= 1'b0;
         rx_bus.rx_valid   <= 1'b0;
         rx_bus.rx_data    <= 8'd0;
         rx_bus.parity_err <= 1'b0;
         rx_bus.frame_err  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         hist              <= 2'b11;
`endif
      end else begin
         rx_bus.rx_valid <= 1'b0;
         if (sample_tick && (state != IDLE)) begin
            tick_cnt <= tick_cnt + 4'd1;
`ifdef UART_RX_MAJORITY_EN
            hist     <= {hist[0], rx_s};
`endif
         end
         case (state)
            IDLE: begin
               // A tick coinciding with the edge is deliberately not counted.
               if (rx_enable && !rx_s) begin
                  cfg_q      <= cfg_reg;
                  shift_q    <= 8'd0;
                  tick_cnt   <= 4'd0;
                  par_flag   <= 1'b0;
                  frame_flag <= 1'b0;
                  rx_busy    <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
               if (dec_tick) begin
                  if (!bit_val) begin
                     tick_cnt <= 4'd0;
                     bit_cnt  <= 4'd0;
                     state    <= DATA;
                  end else begin
                     rx_busy  <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            DATA: begin
               if (dec_tick) begin
                  shift_q[bit_cnt[2:0]] <= bit_val;
                  if (last_data) begin
                     bit_cnt <= 4'd0;
                     state   <= cfg_q[3] ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (dec_tick) begin
                  par_flag <= bit_val ^ (^shift_q) ^ cfg_q[4];
                  state    <= STOP;
               end
            end
            STOP: begin
               if (dec_tick) begin
                  if (cfg_q[2] && (bit_cnt == 4'd0)) begin
                     bit_cnt    <= 4'd1;
                     frame_flag <= frame_flag | ~bit_val;
                  end else begin
                     // Leave at mid-stop so a back-to-back start edge is not missed.
                     rx_bus.rx_valid   <= 1'b1;
                     rx_bus.rx_data    <= shift_q;
                     rx_bus.parity_err <= par_flag;
                     rx_bus.frame_err  <= frame_flag | ~bit_val;
                     rx_busy           <= 1'b0;
                     state             <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 4 clk per sample tick, 64 clk per bit.
// Captures every rx_valid strobe and checks data and flags against hand-computed values.
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       rx_enable = 1'b0;
   logic [4:0] cfg_reg = 5'd0;
   logic       rx = 1'b1;
   logic       rx_busy;

   uart_rx_if rx_if ();

   uart_rx dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx_enable   (rx_enable),
      .cfg_reg     (cfg_reg),
      .rx          (rx),
      .rx_busy     (rx_busy),
      .rx_bus      (rx_if)
   );

   always #5 clk = ~clk;

   int tick_div = 0;
   always @(posedge clk) begin
      #1;
      tick_div    = (tick_div + 1) % 4;
      sample_tick = (tick_div == 0);
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   int         vcnt  = 0;
   logic [7:0] cap_data [8];
   logic       cap_pe   [8];
   logic       cap_fe   [8];

   always @(negedge clk) begin
      if (rx_if.rx_valid === 1'b1) begin
         cap_data[vcnt % 8] = rx_if.rx_data;
         cap_pe[vcnt % 8]   = rx_if.parity_err;
         cap_fe[vcnt % 8]   = rx_if.frame_err;
         vcnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic v, input int nclk);
      rx = v;
      repeat (nclk) @(posedge clk);
      #2;
   endtask

   // stop_low drives the first stop bit low for 3/4 of a bit, long enough to be sampled.
   task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                             input logic par_bit, input int nstop, input bit stop_low,
                             input int idle_clk);
      send_bit(1'b0, 64);
      for (int i = 0; i < nbits; i++) send_bit(d[i], 64);
      if (par_en) send_bit(par_bit, 64);
      if (stop_low) begin
         send_bit(1'b0, 48);
         send_bit(1'b1, 16);
      end else begin
         send_bit(1'b1, 64);
      end
      if (nstop == 2) send_bit(1'b1, 64);
      if (idle_clk > 0) send_bit(1'b1, idle_clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      n_cmp++; if (rx_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", rx_if.rx_data); end
      n_cmp++; if (rx_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rx_if.rx_valid); end
      n_cmp++; if (rx_if.parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_pe: got %b expected 0", rx_if.parity_err); end
      n_cmp++; if (rx_if.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b expected 0", rx_if.frame_err); end
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      rst = 1'b0;
      rx_enable = 1'b1;
      send_bit(1'b1, 32);
   endtask

   task automatic test_8n1();
      int v0;
      cfg_reg = 5'b00011;
      v0 = vcnt;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0, 64);
      n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL 8n1_count: got %0d expected 1", vcnt - v0); end
      n_cmp++; if (cap_data[v0 % 8] !== 8'hA5) begin n_bad++; $display("FAIL 8n1_data: got %h expected a5", cap_data[v0 % 8]); end
      n_cmp++; if (cap_pe[v0 % 8] !== 1'b0) begin n_bad++; $display("FAIL 8n1_pe: got %b expected 0", cap_pe[v0 % 8]); end
      n_cmp++; if (cap_fe[v0 % 8] !== 1'b0) begin n_bad++; $display("FAIL 8n1_fe: got %b expected 0", cap_fe[v0 % 8]); end
      n_cmp++; if (rx_if.rx_data !== 8'hA5) begin n_bad++; $display("FAIL 8n1_hold: got %h expected a5", rx_if.rx_data); end
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL 8n1_busy: got %b expected 0", rx_busy); end
   endtask

   task automatic test_5e2();
      int v0;
      cfg_reg = 5'b01100;
      v0 = vcnt;
      send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b0, 64);
      send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b0, 64);
      n_cmp++; if (vcnt !== v0 + 2) begin n_bad++; $display("FAIL 5e2_count: got %0d expected 2", vcnt - v0); end
      n_cmp++; if (cap_data[v0 % 8] !== 8'h13) begin n_bad++; $display("FAIL 5e2_data_good: got %h expected 13", cap_data[v0 % 8]); end
      n_cmp++; if (cap_pe[v0 % 8] !== 1'b0) begin n_bad++; $display("FAIL 5e2_pe_good: got %b expected 0", cap_pe[v0 % 8]); end
      n_cmp++; if (cap_fe[v0 % 8] !== 1'b0) begin n_bad++; $display("FAIL 5e2_fe_good: got %b expected 0", cap_fe[v0 % 8]); end
      n_cmp++; if (cap_data[(v0 + 1) % 8] !== 8'h13) begin n_bad++; $display("FAIL 5e2_data_bad: got %h expected 13", cap_data[(v0 + 1) % 8]); end
      n_cmp++; if (cap_pe[(v0 + 1) % 8] !== 1'b1) begin n_bad++; $display("FAIL 5e2_pe_bad: got %b expected 1", cap_pe[(v0 + 1) % 8]); end
      n_cmp++; if (cap_fe[(v0 + 1) % 8] !== 1'b0) begin n_bad++; $display("FAIL 5e2_fe_bad: got %b expected 0", cap_fe[(v0 + 1) % 8]); end
   endtask

   task automatic test_7o1_frame_err();
      int v0;
      cfg_reg = 5'b11010;
      v0 = vcnt;
      send_frame(8'h7F, 7, 1'b1, 1'b0, 1, 1'b1, 64);
      n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL 7o1_count: got %0d expected 1", vcnt - v0); end
      n_cmp++; if (cap_data[v0 % 8] !== 8'h7F) begin n_bad++; $display("FAIL 7o1_data: got %h expected 7f", cap_data[v0 % 8]); end
      n_cmp++; if (cap_pe[v0 % 8] !== 1'b0) begin n_bad++; $display("FAIL 7o1_pe: got %b expected 0", cap_pe[v0 % 8]); end
      n_cmp++; if (cap_fe[v0 % 8] !== 1'b1) begin n_bad++; $display("FAIL 7o1_fe: got %b expected 1", cap_fe[v0 % 8]); end
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL 7o1_busy: got %b expected 0", rx_busy); end
   endtask

   task automatic test_glitch();
      int v0;
      bit seen;
      cfg_reg = 5'b00011;
      v0 = vcnt;
      seen = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #2;
         if (rx_busy === 1'b1) seen = 1'b1;
      end
      rx = 1'b1;
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise: got %b expected 1", seen); end
      send_bit(1'b1, 32);
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fall: got %b expected 0", rx_busy); end
      send_bit(1'b1, 128);
      n_cmp++; if (vcnt !== v0) begin n_bad++; $display("FAIL glitch_no_valid: got %0d expected 0", vcnt - v0); end
   endtask

   task automatic test_back_to_back();
      int v0;
      cfg_reg = 5'b00011;
      v0 = vcnt;
      send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b0, 0);
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b0, 64);
      n_cmp++; if (vcnt !== v0 + 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", vcnt - v0); end
      n_cmp++; if (cap_data[v0 % 8] !== 8'h00) begin n_bad++; $display("FAIL b2b_data0: got %h expected 00", cap_data[v0 % 8]); end
      n_cmp++; if (cap_data[(v0 + 1) % 8] !== 8'hFF) begin n_bad++; $display("FAIL b2b_data1: got %h expected ff", cap_data[(v0 + 1) % 8]); end
      n_cmp++; if (cap_fe[(v0 + 1) % 8] !== 1'b0) begin n_bad++; $display("FAIL b2b_fe1: got %b expected 0", cap_fe[(v0 + 1) % 8]); end
   endtask

   task automatic test_rst_mid_frame();
      int v0;
      logic [7:0] d;
      cfg_reg = 5'b00011;
      d = 8'h55;
      v0 = vcnt;
      send_bit(1'b0, 64);
      for (int i = 0; i < 3; i++) send_bit(d[i], 64);
      send_bit(d[3], 32);
      rst = 1'b1;
      @(posedge clk);
      #2;
      n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", rx_busy); end
      n_cmp++; if (rx_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", rx_if.rx_valid); end
      n_cmp++; if (rx_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h expected 00", rx_if.rx_data); end
      rst = 1'b0;
      send_bit(1'b1, 192);
      n_cmp++; if (vcnt !== v0) begin n_bad++; $display("FAIL rst_no_valid: got %0d expected 0", vcnt - v0); end
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 64);
      n_cmp++; if (vcnt !== v0 + 1) begin n_bad++; $display("FAIL rst_next_count: got %0d expected 1", vcnt - v0); end
      n_cmp++; if (cap_data[v0 % 8] !== 8'h3C) begin n_bad++; $display("FAIL rst_next_data: got %h expected 3c", cap_data[v0 % 8]); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_5e2();
      test_7o1_frame_err();
      test_glitch();
      test_back_to_back();
      test_rst_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
